axi_stream_slave: RTL and testbench
===================================

Name: axi_stream_slave

Overview:
- AXI-Stream receiver: accepts 256-bit beats from an AXI-Stream master into an internal FIFO.
- Delimits packets on tlast and checks each packet length against an expected beat count.
- Exposes stored beats through a simple read port, plus per-packet status (done pulse, length, error).
- Sits at the sink end of the stream links between the stream master and downstream logic.

Parameters:
- DEPTH, 8, FIFO depth in beats; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- DATA_W, 256, stream data width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tdata  input  DATA_W  stream data.
- s_tvalid  input  1  master has a beat.
- s_tlast  input  1  last beat of the packet.
- s_tready  output  1  slave can accept a beat.
- packet_size  input  4  expected beats per packet; 0 means 16.
- rd_en  input  1  pop one beat from the FIFO.
- rd_data  output  DATA_W  popped beat, registered.
- rd_valid  output  1  rd_data holds a newly popped beat this cycle.
- empty  output  1  FIFO holds no beats.
- full  output  1  FIFO holds DEPTH beats.
- pkt_done  output  1  one-cycle pulse: a packet has completed.
- pkt_len  output  5  beat count of the last completed packet, 1..31.
- len_err  output  1  one-cycle pulse with pkt_done when pkt_len differs from the expected count.
- pkt_count  output  8  number of completed packets, wraps at 255->0.

Behaviour:
- Reset, synchronous, active-high:
  - FIFO pointers and count go to 0; FIFO contents are not cleared.
  - empty=1, full=0, s_tready=1.
  - rd_valid=0, rd_data=0, pkt_done=0, len_err=0, pkt_len=0, pkt_count=0.
  - Beat counter goes to 0; state goes to IDLE.
  - Reset mid-packet discards the partial packet; no pkt_done is issued for it.
- Handshake:
  - s_tready = ~full, derived only from the registered FIFO count and never from s_tvalid.
  - A beat is accepted iff s_tvalid && s_tready on a rising edge.
  - The master may hold s_tvalid high while s_tready is low; nothing is accepted in that case.
- FIFO:
  - An accepted beat is written at the write pointer, which then increments and wraps modulo DEPTH.
  - A pop occurs iff rd_en && ~empty. On a pop, rd_data is loaded from the read pointer and rd_valid=1 on the next cycle; otherwise rd_valid=0 and rd_data holds its value.
  - rd_en while empty is ignored and is not an error.
  - Simultaneous accept and pop leave the count unchanged and both pointers advance.
  - When full, only a pop is possible. The count drops and s_tready rises on the following cycle.
  - A beat written while the FIFO is empty is poppable from the next cycle; there is no fall-through.
  - empty and full are registered, consistent with the count, and updated in the same cycle the count changes.
- Packet state machine, states IDLE and RECV:
  - cnt is 5 bits and saturates at 31.
  - exp is the expected count, latched from packet_size (0 maps to 16) on the first beat of each packet.
  - IDLE, accepted beat with s_tlast=0: latch exp, cnt<=1, go to RECV.
  - IDLE, accepted beat with s_tlast=1: single-beat packet; complete with length 1 against the freshly latched exp; stay in IDLE.
  - RECV, accepted beat with s_tlast=0: cnt<=sat(cnt+1); stay in RECV.
  - RECV, accepted beat with s_tlast=1: complete with length sat(cnt+1); cnt<=0; go to IDLE.
  - No accepted beat: hold state and cnt.
  - Completion, registered and visible one cycle after the tlast beat is accepted:
    - pkt_done=1 and pkt_len=length.
    - len_err=(length != exp).
    - pkt_count increments.
  - pkt_len holds its value until the next completion.
  - Changing packet_size mid-packet has no effect until the next packet's first beat.
- Packet beats are stored in the FIFO regardless of len_err; error handling is downstream.

Test Plan:
- packet_size=3, three beats 0xA,0xB,0xC with tlast on the third and rd_en low:
  - pkt_done pulses 1 cycle after the 3rd accept, with pkt_len=3, len_err=0, pkt_count=1.
  - Three pops then return 0xA,0xB,0xC, each with rd_valid, followed by empty=1.
- packet_size=4, 2-beat packet -> pkt_len=2, len_err=1. Then packet_size=0 and a 16-beat packet with reads running -> pkt_len=16, len_err=0.
- Backpressure, DEPTH=8, s_tvalid held high, rd_en low:
  - 8 beats are accepted, then full=1 and s_tready=0, and the 9th beat is held by the master.
  - One pop -> s_tready=1 on the next cycle, the 9th beat is accepted, and no data is lost or reordered.
- Single-beat packet (tlast on the first beat) with packet_size=1 -> pkt_done, pkt_len=1, len_err=0, state stays IDLE.
- Simultaneous rd_en and accept with count=4 over 10 cycles -> count stays 4 and the popped order matches the written order. rd_en while empty -> rd_valid=0, no pointer change.
- Reset asserted after 2 of 3 beats -> no pkt_done, empty=1, pkt_count=0. A following 3-beat packet reports pkt_len=3, len_err=0.

Source files
------------

// File: rtl/axi_stream_slave.sv
// AXI-Stream sink: buffers beats in a FIFO, delimits packets on tlast and checks each
// packet's beat count against the expected size latched on its first beat.
module axi_stream_slave #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic [3:0]        packet_size,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              pkt_done,
  output logic [4:0]        pkt_len,
  output logic              len_err,
  output logic [7:0]        pkt_count
);

  typedef enum logic {StIdle, StRecv} state_e;

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d, exp_q, exp_d, exp_sel, cnt_inc;
  logic              pkt_done_q, pkt_done_d, len_err_q, len_err_d;
  logic [4:0]        pkt_len_q, pkt_len_d;
  logic [7:0]        pkt_count_q, pkt_count_d;
  logic              accept, pop;

  // Ready depends only on registered occupancy, never on s_tvalid.
  assign s_tready = ~full_q;
  assign accept   = s_tvalid & ~full_q;
  assign pop      = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    empty_d    = (count_d == '0);
    full_d     = (count_d == FullCnt);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_comb begin
    exp_sel     = (packet_size == 4'd0) ? 5'd16 : {1'b0, packet_size};
    cnt_inc     = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    pkt_done_d  = 1'b0;
    len_err_d   = 1'b0;
    pkt_len_d   = pkt_len_q;
    pkt_count_d = pkt_count_q;
    if (accept) begin
      case (state_q)
        StIdle: begin
          exp_d = exp_sel;
          if (s_tlast) begin
            pkt_done_d = 1'b1;
            pkt_len_d  = 5'd1;
            len_err_d  = (exp_sel != 5'd1);
          end else begin
            cnt_d   = 5'd1;
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (s_tlast) begin
            pkt_done_d = 1'b1;
            pkt_len_d  = cnt_inc;
            len_err_d  = (cnt_inc != exp_q);
            cnt_d      = 5'd0;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (pkt_done_d) pkt_count_d = pkt_count_q + 8'd1;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      exp_q       <= '0;
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
      pkt_len_q   <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      pkt_done_q  <= pkt_done_d;
      len_err_q   <= len_err_d;
      pkt_len_q   <= pkt_len_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign len_err   = len_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_stream_slave.sv
// Scoreboard bench for axi_stream_slave: a queue-based reference model predicts pops and
// packet completions; a negedge monitor compares every DUT output against it.
module tb_axi_stream_slave;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid, s_tlast, s_tready;
  logic [3:0]        packet_size;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, empty, full, pkt_done, len_err;
  logic [4:0]        pkt_len;
  logic [7:0]        pkt_count;

  axi_stream_slave #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .packet_size(packet_size), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full), .pkt_done(pkt_done),
    .pkt_len(pkt_len), .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] len;
    logic       err;
  } pkt_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DATA_W-1:0] m_fifo [$];
  logic [DATA_W-1:0] exp_rd [$];
  pkt_t              exp_pkt [$];
  logic [DATA_W-1:0] m_hold_rd;
  logic [4:0]        m_len;
  logic [7:0]        m_pcount;
  int                m_beats;
  int                m_exp;
  bit                m_inpkt;
  bit                acc_last = 1'b0;
  bit                armed    = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: FIFO as a queue, packet length as a plain beat count.
  always @(posedge clk) begin
    bit   do_pop, do_acc;
    pkt_t p;
    int   l;
    if (reset) begin
      armed = 1'b1;
      m_fifo.delete();
      exp_rd.delete();
      exp_pkt.delete();
      m_hold_rd = '0;
      m_len     = '0;
      m_pcount  = '0;
      m_beats   = 0;
      m_exp     = 0;
      m_inpkt   = 1'b0;
      acc_last  = 1'b0;
    end else if (armed) begin
      do_pop   = rd_en && (m_fifo.size() > 0);
      do_acc   = s_tvalid && (m_fifo.size() < DEPTH);
      acc_last = do_acc;
      if (do_pop) begin
        m_hold_rd = m_fifo.pop_front();
        exp_rd.push_back(m_hold_rd);
      end
      if (do_acc) begin
        m_fifo.push_back(s_tdata);
        if (!m_inpkt) begin
          m_exp   = (packet_size == 4'd0) ? 16 : int'(packet_size);
          m_beats = 0;
        end
        m_beats++;
        if (s_tlast) begin
          l     = (m_beats > 31) ? 31 : m_beats;
          p.len = 5'(l);
          p.err = (l != m_exp);
          exp_pkt.push_back(p);
          m_len    = p.len;
          m_pcount = m_pcount + 8'd1;
          m_inpkt  = 1'b0;
        end else begin
          m_inpkt = 1'b1;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    pkt_t p;
    if (armed) begin
      chk("empty", empty, m_fifo.size() == 0);
      chk("full", full, m_fifo.size() == DEPTH);
      chk("s_tready", s_tready, m_fifo.size() < DEPTH);
      if (exp_rd.size() > 0) begin
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_data", rd_data, exp_rd.pop_front());
      end else begin
        chk("rd_valid_idle", rd_valid, 1'b0);
        chk("rd_data_hold", rd_data, m_hold_rd);
      end
      if (exp_pkt.size() > 0) begin
        p = exp_pkt.pop_front();
        chk("pkt_done", pkt_done, 1'b1);
        chk("pkt_len_done", pkt_len, p.len);
        chk("len_err", len_err, p.err);
      end else begin
        chk("pkt_done_idle", pkt_done, 1'b0);
        chk("len_err_idle", len_err, 1'b0);
      end
      chk("pkt_len", pkt_len, m_len);
      chk("pkt_count", pkt_count, m_pcount);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic rd);
    int guard = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1; rd_en = rd;
    do begin
      @(negedge clk);
      guard++;
    end while (!acc_last && guard < 64);
    if (!acc_last) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: actual=not accepted expected=accepted at %0t", $time);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; rd_en = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rd_en = 1'b1;
    while (m_fifo.size() > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    packet_size = 4'd3; rd_en = 1'b0;
    @(negedge clk);
    do_reset(2);
    @(negedge clk);

    // 3-beat packet, then three pops
    packet_size = 4'd3;
    send(256'hA, 1'b0, 1'b0);
    send(256'hB, 1'b0, 1'b0);
    send(256'hC, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);

    // Short packet against size 4, then 16-beat packet with size 0 while reading
    packet_size = 4'd4;
    send(rnd(), 1'b0, 1'b0);
    send(rnd(), 1'b1, 1'b0);
    drain();
    packet_size = 4'd0;
    for (int i = 0; i < 16; i++) send(rnd(), i == 15, 1'b1);
    drain();

    // Backpressure: fill, hold 9th beat, one pop releases it
    packet_size = 4'd9;
    for (int i = 0; i < 8; i++) send(rnd(), 1'b0, 1'b0);
    s_tdata = rnd(); s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    send(s_tdata, 1'b1, 1'b0);
    drain();

    // Single-beat packet
    packet_size = 4'd1;
    send(rnd(), 1'b1, 1'b0);
    drain();

    // Steady state at occupancy 4 with simultaneous push/pop, then reads while empty
    packet_size = 4'd14;
    for (int i = 0; i < 4; i++) send(rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s_tdata = rnd(); s_tlast = (i == 9); s_tvalid = 1'b1; rd_en = 1'b1;
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; rd_en = 1'b0;
    drain();
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;

    // Reset in the middle of a packet
    packet_size = 4'd3;
    send(rnd(), 1'b0, 1'b0);
    send(rnd(), 1'b0, 1'b0);
    do_reset(1);
    @(negedge clk);
    send(rnd(), 1'b0, 1'b0);
    send(rnd(), 1'b0, 1'b0);
    send(rnd(), 1'b1, 1'b0);
    drain();

    // Randomized traffic with valid held until accepted
    for (int c = 0; c < 600; c++) begin
      if (!(s_tvalid && !acc_last)) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = rnd();
        s_tlast  = ($urandom_range(0, 4) == 0);
      end
      rd_en       = ($urandom_range(0, 9) < ((c < 300) ? 4 : 8));
      packet_size = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
